// File: rtl/receiver_controller.sv
// Receive-side byte capture: stores UART RX bytes in a ring buffer and lets the
// board keys browse the stored slots while status flags track overflow and framing errors.
module receiver_controller #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned IDX_W = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [7:0]       rx_data_i,
   input  logic             rx_valid_i,
   input  logic             rx_err_i,
   input  logic             s3_i,
   input  logic             s0_i,
   input  logic             s4_i,
   input  logic             s1_i,
   input  logic             s2_i,
   output logic [7:0]       view_data_o,
   output logic [IDX_W-1:0] view_index_o,
   output logic [IDX_W:0]   count_o,
   output logic             new_flag_o,
   output logic             overflow_o,
   output logic             frame_err_o
);

   localparam logic [IDX_W:0]   FullCnt = (IDX_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0] IdxOne  = IDX_W'(1);
   localparam logic [IDX_W:0]   CntOne  = (IDX_W + 1)'(1);

   logic [7:0]       ram_q [DEPTH];
   logic [7:0]       view_data_q;
   logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [IDX_W-1:0] view_index_q, view_index_d;
   logic [IDX_W:0]   count_q, count_d;
   logic             follow_q, follow_d;
   logic             new_flag_q, new_flag_d;
   logic             overflow_q, overflow_d;
   logic             frame_err_q, frame_err_d;
   logic [4:0]       key_prev_q;
   logic [4:0]       keys, press;
   logic             s0_press, s1_press, s2_press, s3_press, s4_press;
   logic             write_en;

   assign keys  = {s4_i, s3_i, s2_i, s1_i, s0_i};
   assign press = keys & ~key_prev_q;
   assign {s4_press, s3_press, s2_press, s1_press, s0_press} = press;

   // Clear wins over a simultaneous byte; that byte is dropped.
   assign write_en = rx_valid_i & ~s2_press;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      view_index_d = view_index_q;
      count_d      = count_q;
      follow_d     = follow_q;
      new_flag_d   = new_flag_q;
      overflow_d   = overflow_q;
      frame_err_d  = frame_err_q;

      // Sticky flags: an acknowledge clears, a same-edge set overrides it.
      if (s1_press) begin
         overflow_d  = 1'b0;
         frame_err_d = 1'b0;
      end
      if (rx_err_i) begin
         frame_err_d = 1'b1;
      end

      if (s2_press) begin
         wr_ptr_d     = '0;
         count_d      = '0;
         view_index_d = '0;
         new_flag_d   = 1'b0;
         follow_d     = 1'b1;
      end else begin
         if (write_en) begin
            wr_ptr_d = wr_ptr_q + IdxOne;
            if (count_q == FullCnt) begin
               overflow_d = 1'b1;
            end else begin
               count_d = count_q + CntOne;
            end
         end

         if (s4_press) begin
            follow_d     = 1'b1;
            new_flag_d   = 1'b0;
            view_index_d = wr_ptr_q - IdxOne;
         end else if (s3_press || s0_press) begin
            follow_d     = 1'b0;
            view_index_d = s3_press ? view_index_q + IdxOne : view_index_q - IdxOne;
            if (write_en) begin
               new_flag_d = 1'b1;
            end
         end else if (write_en) begin
            if (follow_q) begin
               view_index_d = wr_ptr_q;
            end else begin
               new_flag_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            ram_q[i] <= '0;
         end
         view_data_q  <= '0;
         wr_ptr_q     <= '0;
         view_index_q <= '0;
         count_q      <= '0;
         follow_q     <= 1'b1;
         new_flag_q   <= 1'b0;
         overflow_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         // Keys held through reset must not register as presses.
         key_prev_q   <= '1;
      end else begin
         if (s2_press) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               ram_q[i] <= '0;
            end
         end else if (write_en) begin
            ram_q[wr_ptr_q] <= rx_data_i;
         end
         view_data_q  <= ram_q[view_index_q];
         wr_ptr_q     <= wr_ptr_d;
         view_index_q <= view_index_d;
         count_q      <= count_d;
         follow_q     <= follow_d;
         new_flag_q   <= new_flag_d;
         overflow_q   <= overflow_d;
         frame_err_q  <= frame_err_d;
         key_prev_q   <= keys;
      end
   end

   assign view_data_o  = view_data_q;
   assign view_index_o = view_index_q;
   assign count_o      = count_q;
   assign new_flag_o   = new_flag_q;
   assign overflow_o   = overflow_q;
   assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_receiver_controller.sv
// Bench for receiver_controller: directed vector table, hand sequences for overflow and
// reset corner cases, then random traffic compared every cycle against a reference model.
module tb_receiver_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid, rx_err;
   logic       s0, s1, s2, s3, s4;
   logic [7:0] view_data;
   logic [2:0] view_index;
   logic [3:0] count;
   logic       new_flag, overflow, frame_err;

   int n_tests = 0;
   int n_fail  = 0;

   receiver_controller #(.DEPTH(8), .IDX_W(3)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .rx_data_i   (rx_data),
      .rx_valid_i  (rx_valid),
      .rx_err_i    (rx_err),
      .s3_i        (s3),
      .s0_i        (s0),
      .s4_i        (s4),
      .s1_i        (s1),
      .s2_i        (s2),
      .view_data_o (view_data),
      .view_index_o(view_index),
      .count_o     (count),
      .new_flag_o  (new_flag),
      .overflow_o  (overflow),
      .frame_err_o (frame_err)
   );

   always #5 clk = ~clk;

   // Reference model: spec-level state held as plain integers.
   int       m_mem [8];
   int       m_wr, m_cnt, m_view, m_follow, m_new, m_ovf, m_ferr, m_vdata;
   bit [4:0] m_prev;

   function automatic void model_reset();
      foreach (m_mem[i]) m_mem[i] = 0;
      m_wr = 0; m_cnt = 0; m_view = 0; m_follow = 1;
      m_new = 0; m_ovf = 0; m_ferr = 0; m_vdata = 0;
      m_prev = '1;
   endfunction

   // Key vector order: {s4, s3, s2, s1, s0}.
   function automatic void model_step(input bit r, input bit v, input int d, input bit e,
                                      input bit [4:0] k);
      bit [4:0] p;
      int       wr_old;
      if (r) begin
         model_reset();
         return;
      end
      p       = k & ~m_prev;
      m_prev  = k;
      m_vdata = m_mem[m_view];
      if (p[1]) begin
         m_ovf = 0; m_ferr = 0;
      end
      if (e) m_ferr = 1;
      if (p[2]) begin
         foreach (m_mem[i]) m_mem[i] = 0;
         m_wr = 0; m_cnt = 0; m_view = 0; m_new = 0; m_follow = 1;
         return;
      end
      wr_old = m_wr;
      if (v) begin
         m_mem[m_wr] = d;
         m_wr = (m_wr + 1) % 8;
         if (m_cnt == 8) m_ovf = 1;
         else m_cnt++;
      end
      if (p[4]) begin
         m_follow = 1; m_new = 0; m_view = (wr_old + 7) % 8;
      end else if (p[3] || p[0]) begin
         m_follow = 0;
         m_view = (m_view + (p[3] ? 1 : 7)) % 8;
         if (v) m_new = 1;
      end else if (v) begin
         if (m_follow) m_view = wr_old;
         else m_new = 1;
      end
   endfunction

   function automatic int dut_pack();
      return {view_index, count, new_flag, overflow, frame_err, view_data};
   endfunction

   function automatic int model_pack();
      return {m_view[2:0], m_cnt[3:0], m_new[0], m_ovf[0], m_ferr[0], m_vdata[7:0]};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cycle(input bit r, input bit v, input logic [7:0] d, input bit e,
                        input bit [4:0] k);
      rst = r; rx_valid = v; rx_data = d; rx_err = e;
      {s4, s3, s2, s1, s0} = k;
      @(posedge clk);
      #1;
      model_step(r, v, int'(d), e, k);
      chk("model", dut_pack(), model_pack());
   endtask

   typedef struct {
      bit         r, v, e;
      logic [7:0] d;
      bit [4:0]   k;
      int         vi, cnt, nf, ov, fe, vd;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input bit r, input bit v, input int d, input bit e,
                               input bit [4:0] k, input int vi, input int cnt, input int nf,
                               input int ov, input int fe, input int vd);
      vec_t x;
      x.r = r; x.v = v; x.d = d[7:0]; x.e = e; x.k = k;
      x.vi = vi; x.cnt = cnt; x.nf = nf; x.ov = ov; x.fe = fe; x.vd = vd;
      tbl.push_back(x);
   endfunction

   initial begin
      model_reset();
      rst = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_err = 1'b0;
      {s4, s3, s2, s1, s0} = '0;

      //  r  v  d     e  keys      vi cnt nf ov fe vd
      add(1, 0, 0,    0, 5'b00000, 0, 0, 0, 0, 0, 8'h00);
      add(0, 1, 'h41, 0, 5'b00000, 0, 1, 0, 0, 0, 8'h00);
      add(0, 1, 'h42, 0, 5'b00000, 1, 2, 0, 0, 0, 8'h41);
      add(0, 1, 'h43, 0, 5'b00000, 2, 3, 0, 0, 0, 8'h42);
      add(0, 0, 0,    0, 5'b00000, 2, 3, 0, 0, 0, 8'h43);
      add(0, 0, 0,    0, 5'b00001, 1, 3, 0, 0, 0, 8'h43); // s0: browse back
      add(0, 0, 0,    0, 5'b00000, 1, 3, 0, 0, 0, 8'h42);
      add(0, 1, 'h44, 0, 5'b00000, 1, 4, 1, 0, 0, 8'h42); // write while browsing
      add(0, 0, 0,    0, 5'b10000, 3, 4, 0, 0, 0, 8'h42); // s4: follow again
      add(0, 0, 0,    0, 5'b00000, 3, 4, 0, 0, 0, 8'h44);
      add(0, 0, 0,    0, 5'b01000, 4, 4, 0, 0, 0, 8'h44); // s3
      add(0, 0, 0,    0, 5'b00000, 4, 4, 0, 0, 0, 8'h00);
      add(0, 0, 0,    0, 5'b00100, 0, 0, 0, 0, 0, 8'h00); // s2 clear
      add(0, 0, 0,    0, 5'b00000, 0, 0, 0, 0, 0, 8'h00);
      add(0, 0, 0,    0, 5'b00001, 7, 0, 0, 0, 0, 8'h00); // wrap 0 -> 7
      add(0, 0, 0,    0, 5'b00000, 7, 0, 0, 0, 0, 8'h00);
      add(0, 0, 0,    0, 5'b01000, 0, 0, 0, 0, 0, 8'h00); // wrap 7 -> 0
      add(0, 1, 'h55, 0, 5'b00100, 0, 0, 0, 0, 0, 8'h00); // clear beats write
      add(0, 0, 0,    0, 5'b00000, 0, 0, 0, 0, 0, 8'h00);
      add(0, 1, 'h66, 0, 5'b00000, 0, 1, 0, 0, 0, 8'h00);
      add(0, 0, 0,    0, 5'b00000, 0, 1, 0, 0, 0, 8'h66);
      add(0, 0, 0,    1, 5'b00010, 0, 1, 0, 0, 1, 8'h66); // rx_err beats s1
      add(0, 0, 0,    0, 5'b00000, 0, 1, 0, 0, 1, 8'h66);
      add(0, 0, 0,    0, 5'b00010, 0, 1, 0, 0, 0, 8'h66);
      add(0, 0, 0,    0, 5'b00000, 0, 1, 0, 0, 0, 8'h66);

      foreach (tbl[i]) begin
         cycle(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].e, tbl[i].k);
         chk($sformatf("vec%0d", i), dut_pack(),
             {tbl[i].vi[2:0], tbl[i].cnt[3:0], tbl[i].nf[0], tbl[i].ov[0], tbl[i].fe[0],
              tbl[i].vd[7:0]});
      end

      // Overflow: nine writes into an empty buffer.
      cycle(0, 0, 0, 0, 5'b00100);
      cycle(0, 0, 0, 0, 5'b00000);
      for (int i = 1; i <= 9; i++) cycle(0, 1, 8'(i), 0, 5'b00000);
      chk("ovf_count", int'(count), 8);
      chk("ovf_flag", int'(overflow), 1);
      chk("ovf_view", int'(view_index), 0);
      cycle(0, 0, 0, 0, 5'b00000);
      chk("ovf_slot0", int'(view_data), 'h09);
      cycle(0, 0, 0, 0, 5'b00010);
      chk("ovf_ack", int'(overflow), 0);

      // s3 held through reset release must not browse.
      cycle(1, 0, 0, 0, 5'b01000);
      cycle(1, 0, 0, 0, 5'b01000);
      cycle(0, 0, 0, 0, 5'b01000);
      cycle(0, 0, 0, 0, 5'b01000);
      chk("rst_held_s3", int'(view_index), 0);
      cycle(0, 1, 8'h77, 0, 5'b01000);
      chk("rst_held_follow", int'(view_index), 0);
      cycle(0, 0, 0, 0, 5'b00000);

      // Random traffic; the model check inside cycle() covers every step.
      for (int i = 0; i < 3000; i++) begin
         bit [4:0] k;
         k[0] = ($urandom_range(0, 3) == 0);
         k[1] = ($urandom_range(0, 7) == 0);
         k[2] = ($urandom_range(0, 31) == 0);
         k[3] = ($urandom_range(0, 3) == 0);
         k[4] = ($urandom_range(0, 7) == 0);
         cycle(($urandom_range(0, 299) == 0), $urandom_range(0, 1), 8'($urandom),
               ($urandom_range(0, 19) == 0), k);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
